// File: rtl/dff_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package dff_pkg;

  localparam int unsigned DFF_PIPE_MAX_DEPTH = 64;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready payload channel; master drives valid/data, slave drives ready.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus payload register that fills whenever it is ready.
module dff_pipe_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             rdy_in,
  output logic             rdy_out,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  logic             v_d;
  logic [WIDTH-1:0] d_d;

  // An empty stage always accepts, so bubbles collapse under a stalled output.
  always_comb begin
    rdy_out = !v_q || rdy_in;
    v_d     = v_q;
    d_d     = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (rdy_out) begin
      v_d = up_valid;
      if (up_valid) begin
        d_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Parametrised elastic register pipeline with valid/ready handshake, flush and occupancy count.
// The ready chain is combinational: dn.ready reaches up.ready without a register.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  dff_pipe_if.slave                up,
  dff_pipe_if.master               dn,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OCC_W = occ_w(DEPTH);

  if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("dff_pipe: DEPTH out of range");
  end

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][WIDTH-1:0] up_d;
  logic                        push;
  logic                        pop;
  logic [OCC_W-1:0]            occ_d;
  logic [OCC_W-1:0]            occ_q;

  // Each stage is fed by its predecessor; stage 0 by the producer.
  always_comb begin
    up_v    = '0;
    up_d    = '0;
    up_v[0] = up.valid;
    up_d[0] = up.data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  // Per-stage ready nets live in their own scopes so the chain is not one self-referencing vector.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic rdy_dn;
    logic rdy_up;

    if (i == int'(DEPTH) - 1) begin : g_last
      assign rdy_dn = dn.ready;
    end else begin : g_mid
      assign rdy_dn = g_stage[i+1].rdy_up;
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (up_v[i]),
      .up_data  (up_d[i]),
      .rdy_in   (rdy_dn),
      .rdy_out  (rdy_up),
      .v_q      (v[i]),
      .d_q      (d[i])
    );
  end

  assign up.ready = g_stage[0].rdy_up && !flush;
  assign dn.valid = v[DEPTH-1];
  assign dn.data  = d[DEPTH-1];

  assign push = up.valid && up.ready;
  assign pop  = dn.valid && dn.ready;

  // Occupancy tracks pushes minus pops; flush empties the pipe.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifndef SYNTHESIS
  a_occ_matches_valids: assert property (@(posedge clk) disable iff (!rst_n)
    int'(occ_q) == $countones(v));
`endif

endmodule
